// File: rtl/xm_latch_md_pkg.sv
// Shared decode constants, status codes and the multdiv sequencer state type
// for the execute->memory latch.
package xm_latch_md_pkg;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] OPC_ADDI  = 5'b00101;
    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    localparam logic [31:0] CODE_NONE = 32'd0;
    localparam logic [31:0] CODE_ADD  = 32'd1;
    localparam logic [31:0] CODE_ADDI = 32'd2;
    localparam logic [31:0] CODE_SUB  = 32'd3;
    localparam logic [31:0] CODE_MUL  = 32'd4;
    localparam logic [31:0] CODE_DIV  = 32'd5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    function automatic logic isMul(input logic [31:0] insn);
        return (insn[31:27] == OPC_RTYPE) && (insn[6:2] == ALU_MUL);
    endfunction

    function automatic logic isDiv(input logic [31:0] insn);
        return (insn[31:27] == OPC_RTYPE) && (insn[6:2] == ALU_DIV);
    endfunction

    // Status code for adder-class instructions; CODE_NONE means not overflow-capable.
    function automatic logic [31:0] adderCode(input logic [31:0] insn);
        logic [31:0] code;
        code = CODE_NONE;
        case (insn[31:27])
            OPC_ADDI:  code = CODE_ADDI;
            OPC_RTYPE: begin
                case (insn[6:2])
                    ALU_ADD: code = CODE_ADD;
                    ALU_SUB: code = CODE_SUB;
                    default: code = CODE_NONE;
                endcase
            end
            default:   code = CODE_NONE;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] rewriteDest(input logic [31:0] insn, input logic [4:0] rd);
        return {insn[31:27], rd, insn[21:0]};
    endfunction

endpackage

// File: rtl/xm_latch_md_multdiv_seq.sv
// Multicycle mul/div sequencer: start pulses, upstream stall and captured insn/pc.
// Optional BUSY-cycle counter under XM_STALL_COUNTER_EN.
module multdiv_seq
    import xm_latch_md_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        flush,
    input  logic        xValid,
    input  logic [31:0] xInsn,
    input  logic [31:0] xPc,
    input  logic        mdReady,
    output logic        issue,
    output logic        complete,
    output logic        busy,
    output logic        mdCtrlMult,
    output logic        mdCtrlDiv,
    output logic        stallUpstream,
    output logic [31:0] capInsn,
    output logic [31:0] capPc,
    output logic        capIsDiv
`ifdef XM_STALL_COUNTER_EN
    ,
    output logic [31:0] stallCycles
`endif
);

    mdState_t    stateR;
    mdState_t    nextStateS;
    logic        multPulseR;
    logic        divPulseR;
    logic [31:0] capInsnR;
    logic [31:0] capPcR;
    logic        capIsDivR;
    logic        xIsMulS;
    logic        xIsDivS;

    assign xIsMulS = isMul(xInsn);
    assign xIsDivS = isDiv(xInsn);

    // Issue/complete qualifiers and next-state selection.
    always_comb begin
        nextStateS    = stateR;
        issue         = 1'b0;
        complete      = 1'b0;
        stallUpstream = 1'b0;
        case (stateR)
            IDLE: begin
                issue = xValid && (xIsMulS || xIsDivS) && enable && !flush;
                if (issue) begin
                    nextStateS = BUSY;
                end else begin
                    nextStateS = IDLE;
                end
            end
            BUSY: begin
                complete      = mdReady && !flush;
                stallUpstream = !mdReady && !flush;
                if (flush || mdReady) begin
                    nextStateS = IDLE;
                end else begin
                    nextStateS = BUSY;
                end
            end
            default: nextStateS = IDLE;
        endcase
    end

    // State, start pulses and operand capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateR     <= IDLE;
            multPulseR <= 1'b0;
            divPulseR  <= 1'b0;
            capInsnR   <= 32'd0;
            capPcR     <= 32'd0;
            capIsDivR  <= 1'b0;
        end else begin
            stateR     <= nextStateS;
            multPulseR <= issue && xIsMulS;
            divPulseR  <= issue && xIsDivS;
            if (issue) begin
                capInsnR  <= xInsn;
                capPcR    <= xPc;
                capIsDivR <= xIsDivS;
            end else begin
                capInsnR  <= capInsnR;
                capPcR    <= capPcR;
                capIsDivR <= capIsDivR;
            end
        end
    end

`ifdef XM_STALL_COUNTER_EN
    logic [31:0] stallCyclesR;

    // Free-running count of BUSY cycles; wraps naturally, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCyclesR <= 32'd0;
        end else if (stateR == BUSY) begin
            stallCyclesR <= stallCyclesR + 32'd1;
        end else begin
            stallCyclesR <= stallCyclesR;
        end
    end

    assign stallCycles = stallCyclesR;
`endif

    assign busy       = (stateR == BUSY);
    assign mdCtrlMult = multPulseR;
    assign mdCtrlDiv  = divPulseR;
    assign capInsn    = capInsnR;
    assign capPc      = capPcR;
    assign capIsDiv   = capIsDivR;

endmodule

// File: rtl/xm_latch_md.sv
// Execute->memory pipeline latch with multdiv sequencing and $rstatus exception rewrite.
// Define XM_STALL_COUNTER_EN to add the md_stall_cycles BUSY-cycle counter port.
module xm_latch_md
    import xm_latch_md_pkg::*;
#(
    parameter int RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        flush,
    input  logic        x_valid,
    input  logic [31:0] x_insn,
    input  logic [31:0] x_pc,
    input  logic [31:0] x_alu_out,
    input  logic [31:0] x_data_b,
    input  logic        adder_overflow,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic        stall_upstream,
    output logic        m_valid,
    output logic [31:0] m_insn,
    output logic [31:0] m_pc,
    output logic [31:0] m_o,
    output logic [31:0] m_b
`ifdef XM_STALL_COUNTER_EN
    ,
    output logic [31:0] md_stall_cycles
`endif
);

    localparam logic [4:0] RSTATUS_FIELD = 5'(RSTATUS_REG);

    logic        issueS;
    logic        completeS;
    logic        busyS;
    logic [31:0] capInsnS;
    logic [31:0] capPcS;
    logic        capIsDivS;
    logic [31:0] adderCodeS;
    logic        adderExcS;

    logic        mValidR;
    logic [31:0] mInsnR;
    logic [31:0] mPcR;
    logic [31:0] mOR;
    logic [31:0] mBR;

    multdiv_seq uSeq (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .flush         (flush),
        .xValid        (x_valid),
        .xInsn         (x_insn),
        .xPc           (x_pc),
        .mdReady       (md_ready),
        .issue         (issueS),
        .complete      (completeS),
        .busy          (busyS),
        .mdCtrlMult    (md_ctrl_mult),
        .mdCtrlDiv     (md_ctrl_div),
        .stallUpstream (stall_upstream),
        .capInsn       (capInsnS),
        .capPc         (capPcS),
        .capIsDiv      (capIsDivS)
`ifdef XM_STALL_COUNTER_EN
        ,
        .stallCycles   (md_stall_cycles)
`endif
    );

    assign adderCodeS = adderCode(x_insn);
    assign adderExcS  = x_valid && adder_overflow && (adderCodeS != CODE_NONE);

    // M-stage registers; priority: flush, multdiv completion, BUSY bubble, issue bubble, advance, hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mValidR <= 1'b0;
            mInsnR  <= 32'd0;
            mPcR    <= 32'd0;
            mOR     <= 32'd0;
            mBR     <= 32'd0;
        end else if (flush || (busyS && !completeS) || (enable && issueS)) begin
            mValidR <= 1'b0;
            mInsnR  <= 32'd0;
            mPcR    <= 32'd0;
            mOR     <= 32'd0;
            mBR     <= 32'd0;
        end else if (completeS) begin
            mValidR <= 1'b1;
            mPcR    <= capPcS;
            mBR     <= 32'd0;
            if (md_exception) begin
                mInsnR <= rewriteDest(capInsnS, RSTATUS_FIELD);
                mOR    <= capIsDivS ? CODE_DIV : CODE_MUL;
            end else begin
                mInsnR <= capInsnS;
                mOR    <= md_result;
            end
        end else if (enable) begin
            mValidR <= x_valid;
            mPcR    <= x_pc;
            mBR     <= x_data_b;
            if (adderExcS) begin
                mInsnR <= rewriteDest(x_insn, RSTATUS_FIELD);
                mOR    <= adderCodeS;
            end else begin
                mInsnR <= x_insn;
                mOR    <= x_alu_out;
            end
        end else begin
            mValidR <= mValidR;
            mInsnR  <= mInsnR;
            mPcR    <= mPcR;
            mOR     <= mOR;
            mBR     <= mBR;
        end
    end

    assign m_valid = mValidR;
    assign m_insn  = mInsnR;
    assign m_pc    = mPcR;
    assign m_o     = mOR;
    assign m_b     = mBR;

endmodule

// File: tb/tb_xm_latch_md.sv
// Directed self-checking bench for xm_latch_md.
module tb_xm_latch_md;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        flush;
    logic        x_valid;
    logic [31:0] x_insn;
    logic [31:0] x_pc;
    logic [31:0] x_alu_out;
    logic [31:0] x_data_b;
    logic        adder_overflow;
    logic        md_ready;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic        stall_upstream;
    logic        m_valid;
    logic [31:0] m_insn;
    logic [31:0] m_pc;
    logic [31:0] m_o;
    logic [31:0] m_b;
`ifdef XM_STALL_COUNTER_EN
    logic [31:0] md_stall_cycles;
`endif

    int checks;
    int failures;

    xm_latch_md dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .flush          (flush),
        .x_valid        (x_valid),
        .x_insn         (x_insn),
        .x_pc           (x_pc),
        .x_alu_out      (x_alu_out),
        .x_data_b       (x_data_b),
        .adder_overflow (adder_overflow),
        .md_ready       (md_ready),
        .md_result      (md_result),
        .md_exception   (md_exception),
        .md_ctrl_mult   (md_ctrl_mult),
        .md_ctrl_div    (md_ctrl_div),
        .stall_upstream (stall_upstream),
        .m_valid        (m_valid),
        .m_insn         (m_insn),
        .m_pc           (m_pc),
        .m_o            (m_o),
        .m_b            (m_b)
`ifdef XM_STALL_COUNTER_EN
        ,
        .md_stall_cycles(md_stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] encR(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] encI(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [16:0] imm);
        return {5'b00101, rd, rs, imm};
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs;
        enable = 1'b1; flush = 1'b0; x_valid = 1'b0; x_insn = 32'd0; x_pc = 32'd0;
        x_alu_out = 32'd0; x_data_b = 32'd0; adder_overflow = 1'b0;
        md_ready = 1'b0; md_result = 32'd0; md_exception = 1'b0;
    endtask

    task automatic test_reset;
        idleInputs();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({m_valid, m_insn, m_pc, m_o, m_b} !== 129'd0) begin
            failures++; $display("FAIL reset_m_regs: got %h required 0", {m_valid, m_insn, m_pc, m_o, m_b});
        end
        checks++;
        if ({md_ctrl_mult, md_ctrl_div, stall_upstream} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl: got %b required 000", {md_ctrl_mult, md_ctrl_div, stall_upstream});
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_normal;
        x_valid = 1'b1; x_insn = encR(5'd1, 5'd2, 5'd3, 5'd0); x_pc = 32'h40;
        x_alu_out = 32'h5; x_data_b = 32'h77;
        step();
        checks++;
        if ({m_valid, m_o, m_insn, m_pc, m_b} !== {1'b1, 32'h5, 32'h00443000, 32'h40, 32'h77}) begin
            failures++; $display("FAIL add_latch: got v=%b o=%h i=%h pc=%h b=%h required v=1 o=5 i=00443000 pc=40 b=77",
                                 m_valid, m_o, m_insn, m_pc, m_b);
        end
        enable = 1'b0; x_alu_out = 32'h99; x_pc = 32'h44;
        step();
        checks++;
        if ({m_o, m_pc} !== {32'h5, 32'h40}) begin
            failures++; $display("FAIL enable_hold: got o=%h pc=%h required o=5 pc=40", m_o, m_pc);
        end
        flush = 1'b1;
        step();
        checks++;
        if ({m_valid, m_insn, m_o} !== 65'd0) begin
            failures++; $display("FAIL flush_bubble: got v=%b i=%h o=%h required 0", m_valid, m_insn, m_o);
        end
        flush = 1'b0; enable = 1'b1;
    endtask

    task automatic test_overflow;
        logic [31:0] insns [3];
        logic [31:0] expInsns [3];
        logic [31:0] codes [3];
        insns[0] = encR(5'd1, 5'd2, 5'd3, 5'd0); expInsns[0] = encR(5'd30, 5'd2, 5'd3, 5'd0); codes[0] = 32'd1;
        insns[1] = encI(5'd4, 5'd5, 17'h1FFFF);  expInsns[1] = encI(5'd30, 5'd5, 17'h1FFFF);  codes[1] = 32'd2;
        insns[2] = encR(5'd7, 5'd8, 5'd9, 5'd1); expInsns[2] = encR(5'd30, 5'd8, 5'd9, 5'd1); codes[2] = 32'd3;
        for (int i = 0; i < 3; i++) begin
            x_valid = 1'b1; x_insn = insns[i]; x_alu_out = 32'h8000_0000; adder_overflow = 1'b1;
            step();
            checks++;
            if ({m_o, m_insn, m_valid} !== {codes[i], expInsns[i], 1'b1}) begin
                failures++; $display("FAIL ovf_rewrite[%0d]: got o=%h i=%h v=%b required o=%h i=%h v=1",
                                     i, m_o, m_insn, m_valid, codes[i], expInsns[i]);
            end
        end
        x_valid = 1'b0; x_insn = insns[2];
        step();
        checks++;
        if ({m_o, m_insn} !== {32'h8000_0000, insns[2]}) begin
            failures++; $display("FAIL ovf_invalid_no_rewrite: got o=%h i=%h required o=80000000 i=%h", m_o, m_insn, insns[2]);
        end
        idleInputs();
    endtask

    task automatic test_mul;
        x_valid = 1'b1; x_insn = encR(5'd6, 5'd2, 5'd3, 5'd6); x_pc = 32'h80;
        step();
        for (int i = 0; i < 33; i++) begin
            checks++;
            if ({stall_upstream, md_ctrl_mult, m_valid} !== {1'b1, (i == 0), 1'b0}) begin
                failures++; $display("FAIL mul_busy[%0d]: got stall=%b mult=%b v=%b required stall=1 mult=%b v=0",
                                     i, stall_upstream, md_ctrl_mult, m_valid, (i == 0));
            end
            step();
        end
        md_ready = 1'b1; md_result = 32'h64;
        #1;
        checks++;
        if (stall_upstream !== 1'b0) begin
            failures++; $display("FAIL mul_stall_drop: got %b required 0", stall_upstream);
        end
        step();
        idleInputs();
        checks++;
        if ({m_o, m_valid, m_insn, m_pc} !== {32'h64, 1'b1, encR(5'd6, 5'd2, 5'd3, 5'd6), 32'h80}) begin
            failures++; $display("FAIL mul_result: got o=%h v=%b i=%h pc=%h required o=64 v=1 i=%h pc=80",
                                 m_o, m_valid, m_insn, m_pc, encR(5'd6, 5'd2, 5'd3, 5'd6));
        end
    endtask

    task automatic test_div_exception;
        x_valid = 1'b1; x_insn = encR(5'd9, 5'd1, 5'd0, 5'd7); x_pc = 32'hC0;
        step();
        checks++;
        if ({md_ctrl_div, md_ctrl_mult} !== 2'b10) begin
            failures++; $display("FAIL div_pulse: got div=%b mult=%b required div=1 mult=0", md_ctrl_div, md_ctrl_mult);
        end
        enable = 1'b0;
        step(); step();
        md_ready = 1'b1; md_exception = 1'b1; md_result = 32'h1234;
        #1;
        checks++;
        if (stall_upstream !== 1'b0) begin
            failures++; $display("FAIL div_stall_drop: got %b required 0", stall_upstream);
        end
        step();
        idleInputs();
        checks++;
        if ({m_o, m_insn, m_valid} !== {32'd5, encR(5'd30, 5'd1, 5'd0, 5'd7), 1'b1}) begin
            failures++; $display("FAIL div_exception: got o=%h i=%h v=%b required o=5 i=%h v=1",
                                 m_o, m_insn, m_valid, encR(5'd30, 5'd1, 5'd0, 5'd7));
        end
    endtask

    task automatic test_flush_busy;
        x_valid = 1'b1; x_insn = encR(5'd3, 5'd4, 5'd5, 5'd6);
        step();
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        #1;
        checks++;
        if (stall_upstream !== 1'b0) begin
            failures++; $display("FAIL flush_stall_drop: got %b required 0", stall_upstream);
        end
        step();
        idleInputs();
        for (int i = 0; i < 22; i++) step();
        md_ready = 1'b1; md_result = 32'hDEAD;
        step();
        md_ready = 1'b0;
        checks++;
        if ({m_valid, m_o, stall_upstream, md_ctrl_mult} !== 35'd0) begin
            failures++; $display("FAIL flush_late_ready: got v=%b o=%h stall=%b mult=%b required 0",
                                 m_valid, m_o, stall_upstream, md_ctrl_mult);
        end
    endtask

    task automatic test_back_to_back;
        x_valid = 1'b1; x_insn = encR(5'd1, 5'd1, 5'd1, 5'd6); x_pc = 32'h100;
        step(); step(); step();
        md_ready = 1'b1; md_result = 32'h7;
        step();
        md_ready = 1'b0; x_insn = encR(5'd2, 5'd2, 5'd2, 5'd6); x_pc = 32'h104;
        checks++;
        if ({m_o, m_valid, stall_upstream} !== {32'h7, 1'b1, 1'b0}) begin
            failures++; $display("FAIL b2b_first: got o=%h v=%b stall=%b required o=7 v=1 stall=0", m_o, m_valid, stall_upstream);
        end
        step();
        x_valid = 1'b0;
        checks++;
        if ({md_ctrl_mult, m_valid, stall_upstream} !== 3'b101) begin
            failures++; $display("FAIL b2b_second_start: got mult=%b v=%b stall=%b required 1 0 1",
                                 md_ctrl_mult, m_valid, stall_upstream);
        end
        step();
        md_ready = 1'b1; md_result = 32'h9;
        step();
        md_ready = 1'b0;
        checks++;
        if ({m_o, m_pc, m_valid} !== {32'h9, 32'h104, 1'b1}) begin
            failures++; $display("FAIL b2b_second: got o=%h pc=%h v=%b required o=9 pc=104 v=1", m_o, m_pc, m_valid);
        end
        idleInputs();
    endtask

    task automatic test_reset_mid_busy;
        x_valid = 1'b1; x_insn = encR(5'd5, 5'd6, 5'd7, 5'd7); x_pc = 32'h200;
        step();
        x_valid = 1'b0;
        step(); step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_insn, m_pc, m_o, m_b, stall_upstream, md_ctrl_div, md_ctrl_mult} !== 132'd0) begin
            failures++; $display("FAIL async_reset: got v=%b i=%h o=%h stall=%b div=%b required 0",
                                 m_valid, m_insn, m_o, stall_upstream, md_ctrl_div);
        end
`ifdef XM_STALL_COUNTER_EN
        checks++;
        if (md_stall_cycles !== 32'd0) begin
            failures++; $display("FAIL reset_counter: got %0d required 0", md_stall_cycles);
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
        md_ready = 1'b1; md_result = 32'hBEEF;
        step();
        md_ready = 1'b0;
        checks++;
        if ({m_valid, m_o, stall_upstream} !== 34'd0) begin
            failures++; $display("FAIL late_ready_after_reset: got v=%b o=%h stall=%b required 0", m_valid, m_o, stall_upstream);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_normal();
        test_overflow();
        test_mul();
        test_div_exception();
        test_flush_busy();
        test_back_to_back();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
